// File: rtl/multiword_adder_pkg.sv
// rtl/multiword_adder_pkg.sv - state type and chunk sizing helpers for multiword_adder
package multiword_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_chunks(input int width, input int slice);
        return width / slice;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int calc_cnt_width(input int width, input int slice);
        int k;
        k = width / slice;
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/multiword_adder_if.sv
// rtl/multiword_adder_if.sv - operand/result handshake bundle for multiword_adder
// ovf member exists only when MULTIWORD_ADDER_OVF_EN is defined.
interface multiword_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef MULTIWORD_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef MULTIWORD_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef MULTIWORD_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - N-bit combinational ripple-carry adder slice
module ripple_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_ci,
    output logic [N-1:0] o_s,
    output logic         o_co
);
    logic [N:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar g = 0; g < N; g++) begin : g_bit
        assign o_s[g]   = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_co = w_c[N];
endmodule

// File: rtl/multiword_adder.sv
// rtl/multiword_adder.sv - sequential multi-precision adder, one SLICE-bit chunk per clock
// Optional two's-complement overflow output: define MULTIWORD_ADDER_OVF_EN.
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    multiword_adder_if.slave bus
);
    localparam int K  = calc_chunks(WIDTH, SLICE);
    localparam int CW = calc_cnt_width(WIDTH, SLICE);
    localparam logic [CW-1:0]    LAST       = CW'(K - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({SLICE{1'b1}});

    if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
        $error("multiword_adder: WIDTH must be a positive multiple of SLICE");
    end

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [31:0]      w_sh;
    logic [SLICE-1:0] w_a_chunk;
    logic [SLICE-1:0] w_b_chunk;
    logic [SLICE-1:0] w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sum_next;

    // Chunk mux and write-back are shifts so the index never needs a wide part-select.
    assign w_sh       = 32'(r_cnt) * 32'(SLICE);
    assign w_a_chunk  = SLICE'(r_a >> w_sh);
    assign w_b_chunk  = SLICE'(r_b >> w_sh);
    assign w_sum_next = (r_sum & ~(CHUNK_MASK << w_sh)) | (WIDTH'(w_s) << w_sh);

    ripple_adder #(.N(SLICE)) u_slice (
        .i_a  (w_a_chunk),
        .i_b  (w_b_chunk),
        .i_ci (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

`ifdef MULTIWORD_ADDER_OVF_EN
    logic r_ovf;
    logic w_c_msb;

    // Carry into the top bit recovered from the final chunk's MSB sum.
    assign w_c_msb = w_a_chunk[SLICE-1] ^ w_b_chunk[SLICE-1] ^ w_s[SLICE-1];
    assign bus.ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef MULTIWORD_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.cin;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_co;
                    if (r_cnt == LAST) begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
`ifdef MULTIWORD_ADDER_OVF_EN
                        r_ovf       <= w_c_msb ^ w_co;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_carry;
endmodule

// File: tb/tb_multiword_adder.sv
// tb/tb_multiword_adder.sv - scoreboard bench for multiword_adder (optionally with MULTIWORD_ADDER_OVF_EN)
module tb_multiword_adder;
    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int K     = WIDTH / SLICE;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;
    int   cyc      = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiword_adder_if #(.WIDTH(WIDTH)) bus ();

    multiword_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        logic [WIDTH:0] t;
        exp_t e;
        t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
`ifdef MULTIWORD_ADDER_OVF_EN
        e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (e.sum[WIDTH-1] != a[WIDTH-1]);
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic dut_ovf();
`ifdef MULTIWORD_ADDER_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                            output int acc_cyc);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        @(posedge clk);
        acc_cyc = cyc;
        sb.push_back(model(a, b, c));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, captures the result, then consumes it with a one-cycle out_ready.
    task automatic collect(output exp_t got, output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        got  = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        if (seen) begin
            got = {bus.sum, bus.cout, dut_ovf()};
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, dut_ovf()} !== {1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, expected rdy=1 vld=0 busy=0 sum=0 cout=0 ovf=0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sum, bus.cout, dut_ovf());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_carry_ripple();
        exp_t got, e;
        int lat, acc;
        bit seen;
        start_op(16'hFFFF, 16'h0001, 1'b0, acc);
        n_checks++;
        if ({bus.busy, bus.in_ready} !== 2'b10) begin
            n_fails++;
            $display("FAIL run_flags: got busy=%b rdy=%b, expected busy=1 rdy=0", bus.busy, bus.in_ready);
        end
        collect(got, lat, seen);
        e = sb.pop_front();
        n_checks++;
        if (!seen || lat != K) begin
            n_fails++;
            $display("FAIL ripple_latency: got seen=%b lat=%0d, expected lat=%0d", seen, lat, K);
        end
        n_checks++;
        if (got !== e) begin
            n_fails++;
            $display("FAIL ripple_result: got %h, expected %h", got, e);
        end
    endtask

    task automatic test_basic();
        exp_t got, e;
        int lat, acc;
        bit seen;
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                ra = 16'h1234; rb = 16'h4321; rc = 1'b1;
            end else begin
                ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom_range(0, 1));
            end
            start_op(ra, rb, rc, acc);
            collect(got, lat, seen);
            e = sb.pop_front();
            n_checks++;
            if (!seen || got !== e) begin
                n_fails++;
                $display("FAIL basic_%0d: a=%h b=%h cin=%b got %h (seen=%b), expected %h", i, ra, rb, rc, got, seen, e);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int acc;
        bit seen;
        start_op(16'h00FF, 16'h0001, 1'b0, acc);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (!seen || {bus.sum, bus.cout, bus.out_valid, bus.in_ready} !== {e.sum, e.cout, 1'b1, 1'b0}) begin
                n_fails++;
                $display("FAIL hold_%0d: got sum=%h cout=%b vld=%b rdy=%b, expected sum=%h cout=%b vld=1 rdy=0",
                         i, bus.sum, bus.cout, bus.out_valid, bus.in_ready, e.sum, e.cout);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL release: got vld=%b rdy=%b, expected vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_ignore_in_valid();
        exp_t got, e;
        int lat, acc;
        bit seen;
        start_op(16'h1111, 16'h2222, 1'b0, acc);
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.cin      = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        collect(got, lat, seen);
        e = sb.pop_front();
        n_checks++;
        if (!seen || got !== e) begin
            n_fails++;
            $display("FAIL ignore_result: got %h (seen=%b), expected %h", got, seen, e);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            n_fails++;
            $display("FAIL ignore_idle: got vld=%b rdy=%b, expected vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        exp_t got, e;
        int lat, acc, highs;
        bit seen;
        start_op(16'hAAAA, 16'h5555, 1'b1, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.busy, bus.sum} !== {1'b1, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
            n_fails++;
            $display("FAIL abort_state: got rdy=%b vld=%b busy=%b sum=%h, expected rdy=1 vld=0 busy=0 sum=0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.sum);
        end
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) highs++;
        end
        n_checks++;
        if (highs != 0) begin
            n_fails++;
            $display("FAIL abort_no_pulse: got %0d out_valid cycles, expected 0", highs);
        end
        start_op(16'h0003, 16'h0004, 1'b0, acc);
        collect(got, lat, seen);
        e = sb.pop_front();
        n_checks++;
        if (!seen || got !== e) begin
            n_fails++;
            $display("FAIL after_abort: got %h (seen=%b), expected %h", got, seen, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        int lat, acc, prev;
        bit seen;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), acc);
            if (i > 0) begin
                n_checks++;
                if (acc - prev != K + 2) begin
                    n_fails++;
                    $display("FAIL b2b_interval_%0d: got %0d cycles, expected %0d", i, acc - prev, K + 2);
                end
            end
            prev = acc;
            collect(got, lat, seen);
            e = sb.pop_front();
            n_checks++;
            if (!seen || got !== e) begin
                n_fails++;
                $display("FAIL b2b_result_%0d: got %h (seen=%b), expected %h", i, got, seen, e);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t got, e;
        int lat, acc;
        bit seen;
        logic [WIDTH-1:0] va [2];
        va[0] = 16'h7FFF;
        va[1] = 16'hFFFF;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], 16'h0001, 1'b0, acc);
            collect(got, lat, seen);
            e = sb.pop_front();
            n_checks++;
            if (!seen || got !== e) begin
                n_fails++;
                $display("FAIL ovf_%0d: got sum/cout/ovf %h (seen=%b), expected %h", i, got, seen, e);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_carry_ripple();
        test_basic();
        test_backpressure();
        test_ignore_in_valid();
        test_reset_mid();
        test_back_to_back();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
        $fatal(1);
    end
endmodule
